// File: rtl/fir_pkg.sv
// Shared sizing constants and FSM encoding for the FIR coefficient loader.
package fir_pkg;
    localparam int NUM_MODULE = 4;
    localparam int TAPS       = 10;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int SEL_W      = $clog2(NUM_MODULE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;
endpackage

// File: rtl/fir_coeff_loader_if.sv
// Host-side request/stream signals and the SRAM/MAC bus driven toward the module selector.
interface fir_coeff_loader_if;
    import fir_pkg::*;

    logic              iStart;
    logic              iCoeffValid;
    logic [DATA_W-1:0] iCoeff;
    logic              oCoeffReady;
    logic              iRun;
    logic [SEL_W-1:0]  iRunSel;
    logic [SEL_W-1:0]  oModuleSel;
    logic              oCsnRam;
    logic              oWrnRam;
    logic [ADDR_W-1:0] oAddrRam;
    logic [DATA_W-1:0] oWtDtRam;
    logic              oEnMAC;
    logic              oLoadDone;
    logic              oBusy;

    // master: host issuing requests; slave: the loader itself
    modport master (
        output iStart, iCoeffValid, iCoeff, iRun, iRunSel,
        input  oCoeffReady, oModuleSel, oCsnRam, oWrnRam, oAddrRam,
               oWtDtRam, oEnMAC, oLoadDone, oBusy
    );

    modport slave (
        input  iStart, iCoeffValid, iCoeff, iRun, iRunSel,
        output oCoeffReady, oModuleSel, oCsnRam, oWrnRam, oAddrRam,
               oWtDtRam, oEnMAC, oLoadDone, oBusy
    );
endinterface

// File: rtl/tap_bank_counter.sv
// Wrapping tap counter that carries into a bank counter; last_o flags the final tap of the final bank.
module tap_bank_counter #(
    parameter int TAPS     = 10,
    parameter int NUM_BANK = 4,
    parameter int ADDR_W   = 4,
    parameter int BANK_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] tap_o,
    output logic [BANK_W-1:0] bank_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              tap_last, bank_last;

    assign tap_last  = (tap_q == ADDR_W'(TAPS - 1));
    assign bank_last = (bank_q == BANK_W'(NUM_BANK - 1));

    always_comb begin
        tap_d  = tap_q;
        bank_d = bank_q;
        if (clr_i) begin
            tap_d  = '0;
            bank_d = '0;
        end else if (adv_i) begin
            if (tap_last) begin
                tap_d  = '0;
                bank_d = bank_last ? '0 : bank_q + 1'b1;
            end else begin
                tap_d = tap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tap_q  <= '0;
            bank_q <= '0;
        end else begin
            tap_q  <= tap_d;
            bank_q <= bank_d;
        end
    end

    assign tap_o  = tap_q;
    assign bank_o = bank_q;
    assign last_o = tap_last && bank_last;
endmodule

// File: rtl/fir_coeff_loader.sv
// Loads NUM_MODULE x TAPS coefficients in bank order, then sweeps reads + MAC enables on one bank.
//   state   | meaning
//   IDLE    | bus idle, waiting for iStart
//   LOAD    | accepting coefficient beats, one SRAM write per beat
//   RUN     | read sweep + MAC enable on iRunSel while iRun is high
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst,
    fir_coeff_loader_if.slave  host
);
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              csn_q, csn_d;
    logic              wrn_q, wrn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              ld_clr, ld_adv, ld_last;
    logic [ADDR_W-1:0] ld_tap;
    logic [SEL_W-1:0]  ld_bank;
    logic              rd_clr, rd_adv;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank_unused, rd_last_unused;

    tap_bank_counter #(
        .TAPS(TAPS), .NUM_BANK(NUM_MODULE), .ADDR_W(ADDR_W), .BANK_W(SEL_W)
    ) u_load_cnt (
        .clk_i(iClk), .rst_i(iRst), .clr_i(ld_clr), .adv_i(ld_adv),
        .tap_o(ld_tap), .bank_o(ld_bank), .last_o(ld_last)
    );

    tap_bank_counter #(
        .TAPS(TAPS), .NUM_BANK(1), .ADDR_W(ADDR_W), .BANK_W(1)
    ) u_read_cnt (
        .clk_i(iClk), .rst_i(iRst), .clr_i(rd_clr), .adv_i(rd_adv),
        .tap_o(rd_addr), .bank_o(rd_bank_unused), .last_o(rd_last_unused)
    );

    assign host.oCoeffReady = (state_q == ST_LOAD);
    assign accept           = host.iCoeffValid && (state_q == ST_LOAD);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        csn_d   = 1'b1;
        wrn_d   = 1'b1;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        ld_clr  = 1'b0;
        ld_adv  = 1'b0;
        rd_clr  = 1'b0;
        rd_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_d  = '0;
                addr_d = '0;
                if (host.iStart) begin
                    state_d = ST_LOAD;
                    ld_clr  = 1'b1;
                    rd_clr  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    csn_d  = 1'b0;
                    wrn_d  = 1'b0;
                    sel_d  = ld_bank;
                    addr_d = ld_tap;
                    data_d = host.iCoeff;
                    ld_adv = 1'b1;
                    if (ld_last) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // a reload request outranks the read sweep
                if (host.iStart) begin
                    state_d = ST_LOAD;
                    ld_clr  = 1'b1;
                    rd_clr  = 1'b1;
                    sel_d   = '0;
                    addr_d  = '0;
                end else if (host.iRun) begin
                    csn_d  = 1'b0;
                    en_d   = 1'b1;
                    sel_d  = host.iRunSel;
                    addr_d = rd_addr;
                    rd_adv = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign host.oModuleSel = sel_q;
    assign host.oCsnRam    = csn_q;
    assign host.oWrnRam    = wrn_q;
    assign host.oAddrRam   = addr_q;
    assign host.oWtDtRam   = data_q;
    assign host.oEnMAC     = en_q;
    assign host.oLoadDone  = done_q;
    assign host.oBusy      = busy_q;
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Control-side initiator for the four-bank FIR array; generates the select, SRAM and MAC-enable bus that the module selector fans out to the four SpSram + MAC pairs.
- Accepts a coefficient stream (valid/ready) and writes NUM_MODULE x TAPS coefficients in bank order.
- Then enters run mode, issuing sequential coefficient reads and MAC enables to one host-selected bank.

Parameters:
- NUM_MODULE, 4, number of FIR banks; oModuleSel width = clog2(NUM_MODULE) = 2.
- TAPS, 10, coefficients per bank; valid addresses 0..TAPS-1; must be <= 2^ADDR_W.
- ADDR_W, 4, SRAM address width.
- DATA_W, 16, coefficient width.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset; synchronous, active-high.
- iStart  in  1  one-cycle request to begin a full coefficient load.
- iCoeffValid  in  1  coefficient stream valid.
- iCoeff  in  DATA_W  coefficient data.
- oCoeffReady  out  1  loader accepts a coefficient this cycle.
- iRun  in  1  level; enables MAC/read sweep while in RUN.
- iRunSel  in  2  bank to run.
- oModuleSel  out  2  bank select to the module selector.
- oCsnRam  out  1  SRAM chip select, active-low.
- oWrnRam  out  1  SRAM write enable, active-low.
- oAddrRam  out  ADDR_W  SRAM address.
- oWtDtRam  out  DATA_W  SRAM write data.
- oEnMAC  out  1  MAC enable.
- oLoadDone  out  1  one-cycle pulse when the last coefficient write is driven.
- oBusy  out  1  high while in LOAD.

Behaviour:
- Reset and state:
  - Clock iClk; reset iRst is synchronous and active-high. It is fixed and wins over every other input.
  - FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- Output registers:
  - All bus outputs are registered.
  - Reset and idle values: oModuleSel=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oEnMAC=0, oLoadDone=0, oBusy=0.
  - oCoeffReady is combinational: high exactly when state==LOAD.
- IDLE:
  - Bus outputs hold idle values.
  - iStart moves to LOAD and clears counters: bank=0, tap=0.
- LOAD:
  - oBusy=1.
  - Accepted beat (iCoeffValid & oCoeffReady): on the next cycle, oCsnRam=0, oWrnRam=0, oModuleSel=bank, oAddrRam=tap, oWtDtRam=iCoeff. Latency is 1 cycle.
  - Cycle without an accepted beat: next cycle oCsnRam=1, oWrnRam=1; addr, data and sel hold.
  - Counter advance per beat: tap++. When tap==TAPS-1, tap wraps to 0 and bank++.
  - Final beat (bank==NUM_MODULE-1, tap==TAPS-1):
    - The next cycle carries that write with oLoadDone=1.
    - The FSM goes to RUN and oCoeffReady drops.
    - Exactly 40 beats are accepted per load with defaults.
  - iStart during LOAD is ignored.
  - iRun is ignored during LOAD.
- RUN:
  - oWrnRam=1 always.
  - While iRun=1, each cycle: oCsnRam=0, oEnMAC=1, oModuleSel=iRunSel (registered), oAddrRam=rd.
    - rd is a read counter 0..TAPS-1 that wraps to 0 after TAPS-1.
  - While iRun=0: oCsnRam=1, oEnMAC=0, rd holds.
  - A change of iRunSel takes effect the next cycle; rd does not reset.
  - iStart in RUN moves to LOAD with counters cleared and rd=0. Outputs return to idle values on the next cycle, then the LOAD rules apply.
- Reset mid-LOAD: a partial load is abandoned with no further writes; the host must re-issue iStart.
- oWtDtRam holds its last value outside writes.

Decomposition:
- Shared package fir_pkg:
  - constants NUM_MODULE, TAPS, ADDR_W, DATA_W, SEL_W;
  - FSM state encoding ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2.
- One natural sub-module, tap_bank_counter:
  - wrapping tap counter with bank carry;
  - reused for the load counters (bank output used) and the run read counter (bank output unused).

Test Plan:
1. Reset then idle: assert iRst for 2 cycles, deassert -> oCsnRam=1, oWrnRam=1, oAddrRam=0, oEnMAC=0, oCoeffReady=0.
2. Full load, back-to-back: iStart, then 40 beats with iCoeff=16'h0100+n.
   - Beat 0 -> next cycle oModuleSel=0, oAddrRam=0, oWtDtRam=16'h0100, Csn/Wrn=0.
   - Beat 10 -> sel=1, addr=0.
   - Beat 39 -> sel=3, addr=9, data=16'h0127, with oLoadDone pulsed.
   - Then oCoeffReady=0.
3. Back-pressure: drop iCoeffValid for 3 cycles after beat 5 -> 3 cycles with Csn=1, Wrn=1, addr held at 5; beat 6 writes addr=6 with no skipped address.
4. Run sweep: after load, iRun=1, iRunSel=2 for 12 cycles -> oModuleSel=2, oEnMAC=1, Wrn=1, oAddrRam=0..9,0,1.
   - Then iRun=0 -> oEnMAC=0, Csn=1, addr holds 1.
5. Reset mid-load: iRst after beat 17 -> next cycle state IDLE, Csn=1, oBusy=0. A fresh iStart restarts at sel=0, addr=0.
6. iStart ignored in LOAD and re-load from RUN: iStart pulse at beat 20 -> no counter reset.
   - iStart in RUN -> oEnMAC=0, Csn=1 the next cycle; the new load begins at sel=0, addr=0.
